// File: rtl/twd_mul_stage.sv
// twd_mul_stage
//   Twiddle-rotation stage placed between a butterfly and the next
//   commutator/butterfly of the pipelined FFT. It takes LANES butterfly
//   sum/difference pairs per beat. The sum path is delayed unchanged. The
//   difference path is rotated by a twiddle picked from a valid-qualified
//   beat counter. The result is rounded and saturated, with a fixed 2-cycle
//   latency.
//
// Parameters
//   WIDTH   : sample MSB index; samples are signed WIDTH+1 bits
//   LANES   : parallel complex lanes per beat
//   BLK_LEN : accepted beats per twiddle segment
//   MODE    : 0 = {1, -j}; 1 = {1, W8^1, -j, W8^3}
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   i_valid, i_clr           : beat valid, synchronous segment-counter clear
//   i_sum_re/im, i_diff_re/im: butterfly sum and difference, per lane
//   o_valid                  : output beat valid (i_valid delayed 2 cycles)
//   o_sum_re/im, o_diff_re/im: delayed sum and rotated difference, per lane
module twd_mul_stage #(
  parameter int WIDTH   = 9,
  parameter int LANES   = 16,
  parameter int BLK_LEN = 8,
  parameter int MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    i_clr,
  input  logic signed [WIDTH:0]   i_sum_re  [LANES],
  input  logic signed [WIDTH:0]   i_sum_im  [LANES],
  input  logic signed [WIDTH:0]   i_diff_re [LANES],
  input  logic signed [WIDTH:0]   i_diff_im [LANES],
  output logic                    o_valid,
  output logic signed [WIDTH:0]   o_sum_re  [LANES],
  output logic signed [WIDTH:0]   o_sum_im  [LANES],
  output logic signed [WIDTH:0]   o_diff_re [LANES],
  output logic signed [WIDTH:0]   o_diff_im [LANES]
);

  localparam int NSEG    = (MODE == 1) ? 4 : 2;
  localparam int CNT_LEN = BLK_LEN * NSEG;
  localparam int CW      = $clog2(CNT_LEN);
  // a+b and b-a need one extra bit to be exact
  localparam int SW      = WIDTH + 2;
  // product headroom: SW bits times a 9-bit constant plus the rounding term
  localparam int PW      = WIDTH + 11;

  localparam logic [CW-1:0] CNT_MAX = CW'(CNT_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] BLK     = CW'(BLK_LEN);

  localparam logic signed [PW-1:0] C_MUL  = PW'(181);
  localparam logic signed [PW-1:0] C_RND  = PW'(128);
  localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** WIDTH) - 1);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-(2 ** WIDTH));

  // Encodings line up with the MODE 1 segment index so it maps directly
  typedef enum logic [1:0] {
    ROT_ONE = 2'd0,
    ROT_W1  = 2'd1,
    ROT_NJ  = 2'd2,
    ROT_W3  = 2'd3
  } rot_e;

  logic [CW-1:0] cnt;
  logic [1:0]    seg;
  rot_e          rot_sel;

  logic                  s1_valid;
  rot_e                  s1_rot;
  logic signed [WIDTH:0] s1_sum_re [LANES];
  logic signed [WIDTH:0] s1_sum_im [LANES];
  logic signed [WIDTH:0] s1_a      [LANES];
  logic signed [WIDTH:0] s1_b      [LANES];
  logic signed [SW-1:0]  s1_apb    [LANES];
  logic signed [SW-1:0]  s1_bma    [LANES];

  logic signed [WIDTH:0] rot_re [LANES];
  logic signed [WIDTH:0] rot_im [LANES];

  // C*s with round-half-up: (s*181 + 128) >>> 8
  function automatic logic signed [PW-1:0] c_mul(input logic signed [SW-1:0] s);
    logic signed [PW-1:0] prod;
    prod = PW'(s) * C_MUL + C_RND;
    return prod >>> 8;
  endfunction

  function automatic logic signed [WIDTH:0] sat(input logic signed [PW-1:0] x);
    if (x > SAT_HI)
      return SAT_HI[WIDTH:0];
    else if (x < SAT_LO)
      return SAT_LO[WIDTH:0];
    else
      return x[WIDTH:0];
  endfunction

  // A clear in the same cycle as a valid beat forces that beat into segment 0
  always_comb begin
    seg     = i_clr ? 2'd0 : 2'(cnt / BLK);
    rot_sel = ROT_ONE;
    if (MODE == 1)
      rot_sel = rot_e'(seg);
    else if (seg[0])
      rot_sel = ROT_NJ;
  end

  // Counts accepted beats only. A clear wins over the increment, but a
  // valid beat that arrives with the clear still counts as the first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (i_clr)
      cnt <= i_valid ? CNT_ONE : '0;
    else if (i_valid)
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_ONE;
  end

  // Stage 1 captures the rotation select, the operands and the exact
  // a+b / b-a. Data registers load only on valid beats, so bubbles cost
  // no toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rot   <= ROT_ONE;
      for (int l = 0; l < LANES; l++) begin
        s1_sum_re[l] <= '0;
        s1_sum_im[l] <= '0;
        s1_a[l]      <= '0;
        s1_b[l]      <= '0;
        s1_apb[l]    <= '0;
        s1_bma[l]    <= '0;
      end
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_rot <= rot_sel;
        for (int l = 0; l < LANES; l++) begin
          s1_sum_re[l] <= i_sum_re[l];
          s1_sum_im[l] <= i_sum_im[l];
          s1_a[l]      <= i_diff_re[l];
          s1_b[l]      <= i_diff_im[l];
          s1_apb[l]    <= SW'(i_diff_re[l]) + SW'(i_diff_im[l]);
          s1_bma[l]    <= SW'(i_diff_im[l]) - SW'(i_diff_re[l]);
        end
      end
    end
  end

  // Rotation, rounding and saturation for every lane. Negations are done
  // at full product width so that -(-2^WIDTH) clips instead of wrapping.
  always_comb begin
    logic signed [PW-1:0] ax, bx, pp, pm, re_x, im_x;
    for (int l = 0; l < LANES; l++) begin
      ax = PW'(s1_a[l]);
      bx = PW'(s1_b[l]);
      pp = c_mul(s1_apb[l]);
      pm = c_mul(s1_bma[l]);
      re_x = ax;
      im_x = bx;
      case (s1_rot)
        ROT_W1: begin
          re_x = pp;
          im_x = pm;
        end
        ROT_NJ: begin
          re_x = bx;
          im_x = -ax;
        end
        ROT_W3: begin
          re_x = pm;
          im_x = -pp;
        end
        default: begin
          re_x = ax;
          im_x = bx;
        end
      endcase
      rot_re[l] = sat(re_x);
      rot_im[l] = sat(im_x);
    end
  end

  // Stage 2 holds its data between valid beats, so the outputs stay
  // stable while o_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        o_sum_re[l]  <= '0;
        o_sum_im[l]  <= '0;
        o_diff_re[l] <= '0;
        o_diff_im[l] <= '0;
      end
    end else begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        for (int l = 0; l < LANES; l++) begin
          o_sum_re[l]  <= s1_sum_re[l];
          o_sum_im[l]  <= s1_sum_im[l];
          o_diff_re[l] <= rot_re[l];
          o_diff_im[l] <= rot_im[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_twd_mul_stage.sv
// tb_twd_mul_stage
//   Directed bench for twd_mul_stage. It builds one MODE 0 and one MODE 1
//   instance that share the same stimulus; dut_sel picks the instance whose
//   outputs are compared. Every stimulus beat carries its hand-computed
//   expected rotated difference. The bench delays that expectation by two
//   cycles and compares it at the output.
module tb_twd_mul_stage;

  localparam int W = 9;
  localparam int L = 4;
  localparam int B = 8;

  typedef logic signed [W:0] samp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  i_valid = 1'b0;
  logic  i_clr = 1'b0;
  samp_t i_sum_re [L];
  samp_t i_sum_im [L];
  samp_t i_diff_re [L];
  samp_t i_diff_im [L];

  logic  o0_valid, o1_valid;
  samp_t o0_sum_re [L], o0_sum_im [L], o0_diff_re [L], o0_diff_im [L];
  samp_t o1_sum_re [L], o1_sum_im [L], o1_diff_re [L], o1_diff_im [L];

  int    dut_sel = 0;
  string phase = "init";
  int    checks = 0;
  int    passed = 0;
  int    fails = 0;

  // expectation for the beat driven one cycle earlier, and the last valid
  // output values that the DUT must hold during bubbles
  logic  prev_v = 1'b0;
  int    prev_sre, prev_sim, prev_dre, prev_dim;
  logic  hold_z = 1'b1;
  int    hold_sre, hold_sim, hold_dre, hold_dim;

  twd_mul_stage #(.WIDTH(W), .LANES(L), .BLK_LEN(B), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_clr(i_clr),
    .i_sum_re(i_sum_re), .i_sum_im(i_sum_im),
    .i_diff_re(i_diff_re), .i_diff_im(i_diff_im),
    .o_valid(o0_valid), .o_sum_re(o0_sum_re), .o_sum_im(o0_sum_im),
    .o_diff_re(o0_diff_re), .o_diff_im(o0_diff_im)
  );

  twd_mul_stage #(.WIDTH(W), .LANES(L), .BLK_LEN(B), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_clr(i_clr),
    .i_sum_re(i_sum_re), .i_sum_im(i_sum_im),
    .i_diff_re(i_diff_re), .i_diff_im(i_diff_im),
    .o_valid(o1_valid), .o_sum_re(o1_sum_re), .o_sum_im(o1_sum_im),
    .o_diff_re(o1_diff_re), .o_diff_im(o1_diff_im)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Compares the selected instance against one expected beat. Sums carry a
  // per-lane offset (+l on re, -l on im) so lane mix-ups show up. ez means
  // every output must be zero (the post-reset state).
  task automatic checkOutput(input logic ev, input logic ez,
                             input int esr, input int esi,
                             input int edr, input int edi);
    logic  ov;
    samp_t osr, osi, odr, odi, xsr, xsi, xdr, xdi;
    ov = (dut_sel == 1) ? o1_valid : o0_valid;
    checks++;
    assert (ov === ev) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s o_valid got %b want %b", phase, ov, ev);
    end
    for (int l = 0; l < L; l++) begin
      osr = (dut_sel == 1) ? o1_sum_re[l]  : o0_sum_re[l];
      osi = (dut_sel == 1) ? o1_sum_im[l]  : o0_sum_im[l];
      odr = (dut_sel == 1) ? o1_diff_re[l] : o0_diff_re[l];
      odi = (dut_sel == 1) ? o1_diff_im[l] : o0_diff_im[l];
      xsr = ez ? samp_t'(0) : samp_t'(esr + l);
      xsi = ez ? samp_t'(0) : samp_t'(esi - l);
      xdr = ez ? samp_t'(0) : samp_t'(edr);
      xdi = ez ? samp_t'(0) : samp_t'(edi);
      checks++;
      assert (osr === xsr) passed++;
      else begin
        fails++;
        $error("[TB] FAIL %s sum_re lane %0d got %0d want %0d", phase, l, osr, xsr);
      end
      checks++;
      assert (osi === xsi) passed++;
      else begin
        fails++;
        $error("[TB] FAIL %s sum_im lane %0d got %0d want %0d", phase, l, osi, xsi);
      end
      checks++;
      assert (odr === xdr) passed++;
      else begin
        fails++;
        $error("[TB] FAIL %s diff_re lane %0d got %0d want %0d", phase, l, odr, xdr);
      end
      checks++;
      assert (odi === xdi) passed++;
      else begin
        fails++;
        $error("[TB] FAIL %s diff_im lane %0d got %0d want %0d", phase, l, odi, xdi);
      end
    end
  endtask

  // One clock cycle: drive a beat, step past the edge, then check the beat
  // from one cycle earlier, which has just reached the output registers.
  task automatic applyStimulus(input logic v, input logic c,
                               input int dre, input int dim,
                               input int sre, input int sim,
                               input int edr, input int edi);
    i_valid = v;
    i_clr   = c;
    for (int l = 0; l < L; l++) begin
      i_sum_re[l]  = samp_t'(sre + l);
      i_sum_im[l]  = samp_t'(sim - l);
      i_diff_re[l] = samp_t'(dre);
      i_diff_im[l] = samp_t'(dim);
    end
    @(posedge clk);
    #1;
    if (prev_v) begin
      hold_z   = 1'b0;
      hold_sre = prev_sre;
      hold_sim = prev_sim;
      hold_dre = prev_dre;
      hold_dim = prev_dim;
    end
    checkOutput(prev_v, hold_z, hold_sre, hold_sim, hold_dre, hold_dim);
    prev_v   = v;
    prev_sre = sre;
    prev_sim = sim;
    prev_dre = edr;
    prev_dim = edi;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is raised mid-cycle. Outputs must clear before any clock edge.
  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    checkOutput(1'b0, 1'b1, 0, 0, 0, 0);
    i_valid = 1'b0;
    i_clr   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst    = 1'b0;
    prev_v = 1'b0;
    hold_z = 1'b1;
  endtask

  initial begin
    for (int l = 0; l < L; l++) begin
      i_sum_re[l]  = '0;
      i_sum_im[l]  = '0;
      i_diff_re[l] = '0;
      i_diff_im[l] = '0;
    end

    // MODE 0: 17 consecutive beats. Beats 8-15 are rotated by -j.
    dut_sel = 0;
    phase = "m0_reset";
    doReset();
    phase = "m0_run17";
    for (int i = 0; i < 17; i++) begin
      if (i >= 8 && i < 16)
        applyStimulus(1'b1, 1'b0, 100, -50, 3, 4, -50, -100);
      else
        applyStimulus(1'b1, 1'b0, 100, -50, 3, 4, 100, -50);
    end
    idle(2);

    // counter sits at 1: fill seg 0, then check -(-512) saturation in seg 1
    phase = "m0_sat";
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 1'b0, 100, -50, 10, -20, 100, -50);
    applyStimulus(1'b1, 1'b0, -512, 7, 10, -20, 7, 511);

    // seg 1 beats 1..4, then a clear on beat 5 restarts in seg 0
    phase = "m0_clear";
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 100, -50, -30, 40, -50, -100);
    applyStimulus(1'b1, 1'b1, 100, -50, -30, 40, 100, -50);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 1'b0, 100, -50, -30, 40, 100, -50);
    applyStimulus(1'b1, 1'b0, 100, -50, -30, 40, -50, -100);
    idle(2);

    // gaps do not advance the counter
    phase = "m0_gaps";
    doReset();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 100, -50, 5, 6, 100, -50);
    idle(6);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 100, -50, 5, 6, 100, -50);
    applyStimulus(1'b1, 1'b0, 100, -50, 5, 6, -50, -100);

    // reset with beats in flight: nothing stale may emerge afterwards
    phase = "m0_midrst";
    applyStimulus(1'b1, 1'b0, 100, -50, 7, 8, -50, -100);
    applyStimulus(1'b1, 1'b0, 100, -50, 7, 8, -50, -100);
    i_valid = 1'b1;
    doReset();
    idle(3);
    applyStimulus(1'b1, 1'b0, 100, -50, 9, 9, 100, -50);
    idle(2);

    // MODE 1: walk all four segments and wrap
    dut_sel = 1;
    phase = "m1_reset";
    doReset();
    phase = "m1_seg0";
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, 100, 0);
    phase = "m1_seg1";
    applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, 71, -71);
    applyStimulus(1'b1, 1'b0, 511, 511, 1, 2, 511, 0);
    applyStimulus(1'b1, 1'b0, -100, 0, 1, 2, -71, 71);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, 71, -71);
    phase = "m1_seg2";
    applyStimulus(1'b1, 1'b0, -512, 7, 1, 2, 7, 511);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, 0, -100);
    phase = "m1_seg3";
    applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, -71, -71);
    applyStimulus(1'b1, 1'b0, -512, -512, 1, 2, 0, 511);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, -71, -71);
    phase = "m1_wrap";
    applyStimulus(1'b1, 1'b0, 100, 0, 1, 2, 100, 0);
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/twd_mul_stage.md
# twd_mul_stage

Parametrised twiddle-rotation stage for the pipelined FFT datapath. It sits between a butterfly stage and the next commutator/butterfly. It takes LANES parallel butterfly sum/difference pairs per beat and passes the sum path through unchanged. The difference path is rotated by a twiddle chosen from a beat counter. It generalises the trivial {1, −j} stage with selectable twiddle sets (including W8 constant multiply), valid-qualified counting, a synchronous segment clear, a registered 2-cycle pipeline, and rounding with saturation.

## Interface
- WIDTH, 9: data MSB index; every sample is signed WIDTH+1 bits.
- LANES, 16: parallel complex lanes per beat (≥1).
- BLK_LEN, 8: accepted beats per twiddle segment (≥1).
- MODE, 0: 0 = twiddle set {1, −j} (2 segments); 1 = {1, W8¹, −j, W8³} (4 segments).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input beat valid.
- i_clr  in  1  synchronous segment-counter clear.
- i_sum_re / i_sum_im  in  [LANES][WIDTH+1] signed  butterfly sum.
- i_diff_re / i_diff_im  in  [LANES][WIDTH+1] signed  butterfly difference.
- o_valid  out  1  output beat valid.
- o_sum_re / o_sum_im / o_diff_re / o_diff_im  out  [LANES][WIDTH+1] signed  results.

## Operation
- Beat counter cnt ranges over 0 … BLK_LEN·NSEG−1, with NSEG = 2 (MODE 0) or 4 (MODE 1).
  - cnt increments only on beats with i_valid=1.
  - It wraps to 0 after its maximum.
  - seg = cnt / BLK_LEN is sampled for the current beat.
- i_clr=1: cnt ← 0 at the next edge, overriding the increment.
  - If i_valid=1 in the same cycle, that beat uses seg 0 and cnt ← 1.
  - i_clr does not flush the pipeline.
- The sum path is delayed 2 cycles with no modification.
- Difference rotation, with a = diff_re, b = diff_im and C = 181/256:
  - seg 0 (×1): (a, b).
  - MODE 0, seg 1 (×−j): (b, −a).
  - MODE 1, seg 1 (×W8¹): (C·(a+b), C·(b−a)).
  - MODE 1, seg 2 (×−j): (b, −a).
  - MODE 1, seg 3 (×W8³): (C·(b−a), −C·(a+b)).
- Arithmetic rules:
  - a+b and b−a are formed at WIDTH+2 bits with no overflow.
  - Each C product = (s·181 + 128) >>> 8 (arithmetic shift, round-half-up).
  - Every rotated result, including −a, saturates to [−2^WIDTH, 2^WIDTH−1]. So −(−2^WIDTH) → 2^WIDTH−1.
- All lanes use the same seg for a given beat.

## Timing
- Latency is 2 cycles in every MODE.
  - Stage 1 registers the segment select, operands and a±b.
  - Stage 2 registers the multiply/round/saturate results.
- o_valid = i_valid delayed 2 cycles. Bubbles propagate unchanged.
- Outputs update only on cycles when stage-2 valid is captured. When o_valid=0 they hold their last values.
- Reset values: o_valid=0, all o_* data = 0, cnt=0, pipeline valid bits 0. All take effect immediately on rst assertion, independent of clk.
- Reset mid-frame: in-flight beats are discarded. The first valid beat after rst deasserts uses seg 0.
- No backpressure: every valid input beat produces exactly one valid output beat.

## Test plan
- MODE 0, BLK_LEN=8, WIDTH=9, 17 consecutive valid beats with all lanes diff=(100,−50), sum=(3,4):
  - outputs 2 cycles later.
  - beats 0–7 give diff (100,−50); beats 8–15 give (−50,−100); beat 16 gives (100,−50).
  - sum is (3,4) throughout.
- MODE 0, seg 1, diff=(−512,7) → (7,511), saturated.
- MODE 1, diff=(100,0):
  - seg 1 → (71,−71).
  - seg 3 → (−71,−71).
  - seg 1 with diff=(511,511) → (511,0), saturated.
- Gaps: 5 valid beats, 6 idle cycles, then 3 valid beats (BLK_LEN=8) → all 8 beats in seg 0; the 9th valid beat is seg 1; o_valid mirrors the gap pattern 2 cycles later.
- Clear: i_clr with i_valid on beat 5 of seg 1 → that beat is seg 0, the next 7 valid beats are seg 0, then seg 1.
- rst asserted mid-frame with 2 beats in flight → o_valid and outputs 0 in the same cycle, no stale beats emerge; the first beat after release is seg 0.
